// File: rtl/sd_pkg.sv
// Shared sigma-delta definitions: decimator width rule, bit-to-sample mapping, common constants.
package sd_pkg;

  localparam int SAMPLE_POS = 1;
  localparam int SAMPLE_NEG = -1;

  localparam int SD_BW            = 16;
  localparam int SD_LOG2R_DEFAULT = 6;

  // Three integrators of a 1-bit stream grow by 3*log2(R) bits, plus sign and +/-1 input.
  function automatic int cic_width(input int log2r);
    return 3 * log2r + 2;
  endfunction

endpackage

// File: rtl/sd_integ.sv
// W-bit registered modular accumulator with synchronous active-low clear.
// Latency 1 cycle; no backpressure, accumulates on every edge.
module sd_integ
  import sd_pkg::*;
#(
  parameter int W = cic_width(SD_LOG2R_DEFAULT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);

  always_ff @(posedge clk) begin
    if (!rst_n) acc <= '0;
    else        acc <= acc + din;
  end

endmodule

// File: rtl/sd_cic_decim.sv
// sinc3 decimator by R = 2**LOG2R turning a 1-bit sigma-delta stream into signed PCM.
// One word per R input bits; no stall, bs_in is consumed on every edge.
module sd_cic_decim
  import sd_pkg::*;
#(
  parameter int LOG2R = SD_LOG2R_DEFAULT,
  parameter int W     = cic_width(LOG2R)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bs_in,
  output logic signed [W-1:0] pcm_out,
  output logic                pcm_valid
);

  logic [W-1:0]     x, i1, i2, i3, i3_nxt;
  logic [W-1:0]     d1, d2, d3, c1, c2, c3;
  logic [LOG2R-1:0] cnt;
  logic             strobe;

  assign x = bs_in ? W'(SAMPLE_POS) : W'(SAMPLE_NEG);

  sd_integ #(.W(W)) u_i1 (.clk(clk), .rst_n(rst_n), .din(x),  .acc(i1));
  sd_integ #(.W(W)) u_i2 (.clk(clk), .rst_n(rst_n), .din(i1), .acc(i2));
  sd_integ #(.W(W)) u_i3 (.clk(clk), .rst_n(rst_n), .din(i2), .acc(i3));

  // The comb taps i3 as it stands after this edge, so every frame covers exactly
  // R consumed bits including the strobe-edge bit (gives R**3 from the 3rd word on).
  assign i3_nxt = i3 + i2;
  assign c1     = i3_nxt - d1;
  assign c2     = c1 - d2;
  assign c3     = c2 - d3;
  assign strobe = &cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
    end else begin
      cnt       <= cnt + 1'b1;
      pcm_valid <= strobe;
      if (strobe) begin
        d1      <= i3_nxt;
        d2      <= c1;
        d3      <= c2;
        pcm_out <= $signed(c3);
      end
    end
  end

endmodule

// File: tb/tb_sd_cic_decim.sv
// Bench for sd_cic_decim at R=4 and R=64 against a closed-form sinc3 reference.
module tb_sd_cic_decim;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst4, bs4, vld4;
  logic signed [7:0] pcm4;
  logic               rst64, bs64, vld64;
  logic signed [19:0] pcm64;

  int n_tests = 0;
  int n_fail  = 0;
  bit stim[$];

  sd_cic_decim #(.LOG2R(2)) u_r4 (
    .clk(clk), .rst_n(rst4), .bs_in(bs4), .pcm_out(pcm4), .pcm_valid(vld4)
  );
  sd_cic_decim #(.LOG2R(6)) u_r64 (
    .clk(clk), .rst_n(rst64), .bs_in(bs64), .pcm_out(pcm64), .pcm_valid(vld64)
  );

  // Third integrator after k consumed bits, as a binomially weighted sum of samples.
  function automatic longint i3_of(input int k);
    longint s = 0;
    for (int j = 0; j < k; j++) begin
      longint a = k - 1 - j;
      s += (stim[j] ? 1 : -1) * (a * (a - 1) / 2);
    end
    return s;
  endfunction

  // n-th output word (n from 1): third difference of i3 sampled every R bits, wrapped to W bits.
  function automatic longint model_out(input int log2r, input int n);
    longint coef[4] = '{1, -3, 3, -1};
    int     r = 1 << log2r;
    int     w = 3 * log2r + 2;
    longint m = longint'(1) << w;
    longint acc = 0;
    for (int k = 0; k < 4; k++)
      if (n - k > 0) acc += coef[k] * i3_of((n - k) * r);
    acc = acc % m;
    if (acc < 0) acc += m;
    if (acc >= m / 2) acc -= m;
    return acc;
  endfunction

  task automatic tick4(input bit b);
    bs4 = b;
    stim.push_back(b);
    @(posedge clk); #1;
  endtask

  task automatic tick64(input bit b);
    bs64 = b;
    stim.push_back(b);
    @(posedge clk); #1;
  endtask

  task automatic restart4();
    rst4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst4 = 1'b1;
    stim.delete();
  endtask

  task automatic restart64();
    rst64 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst64 = 1'b1;
    stim.delete();
  endtask

  task automatic test_reset();
    rst4 = 1'b0;
    rst64 = 1'b0;
    for (int t = 0; t < 3; t++) begin
      bs4 = 1'($urandom);
      bs64 = 1'($urandom);
      @(posedge clk); #1;
      n_tests += 4;
      if (pcm4 !== 8'sd0)    begin n_fail++; $display("FAIL reset pcm4 got %0d exp 0", pcm4); end
      if (vld4 !== 1'b0)     begin n_fail++; $display("FAIL reset vld4 got %b exp 0", vld4); end
      if (pcm64 !== 20'sd0)  begin n_fail++; $display("FAIL reset pcm64 got %0d exp 0", pcm64); end
      if (vld64 !== 1'b0)    begin n_fail++; $display("FAIL reset vld64 got %b exp 0", vld64); end
    end
  endtask

  task automatic test_constant(input bit b);
    longint tbl[4] = '{4, 44, 64, 64};
    longint sgn = b ? 1 : -1;
    longint last = 0;
    longint exp_v;
    int     nout = 0;
    logic   ev;
    restart4();
    for (int t = 0; t < 24; t++) begin
      tick4(b);
      ev = ((t + 1) % 4) == 0;
      n_tests++;
      if (vld4 !== ev) begin n_fail++; $display("FAIL const%0d valid t=%0d got %b exp %b", b, t, vld4, ev); end
      if (ev) begin
        nout++;
        exp_v = sgn * tbl[(nout > 3) ? 3 : nout - 1];
        n_tests += 2;
        if (longint'(pcm4) !== exp_v)
          begin n_fail++; $display("FAIL const%0d word %0d got %0d exp %0d", b, nout, pcm4, exp_v); end
        if (longint'(pcm4) !== model_out(2, nout))
          begin n_fail++; $display("FAIL const%0d model word %0d got %0d exp %0d", b, nout, pcm4, model_out(2, nout)); end
        last = exp_v;
      end else begin
        n_tests++;
        if (longint'(pcm4) !== last)
          begin n_fail++; $display("FAIL const%0d hold t=%0d got %0d exp %0d", b, t, pcm4, last); end
      end
    end
  endtask

  task automatic test_alternating();
    int nout = 0;
    restart4();
    for (int t = 0; t < 24; t++) begin
      tick4((t % 2) == 0);
      if (((t + 1) % 4) == 0) begin
        nout++;
        n_tests++;
        if (longint'(pcm4) !== model_out(2, nout))
          begin n_fail++; $display("FAIL alt model word %0d got %0d exp %0d", nout, pcm4, model_out(2, nout)); end
        if (nout >= 3) begin
          n_tests++;
          if (pcm4 !== 8'sd0) begin n_fail++; $display("FAIL alt zero word %0d got %0d exp 0", nout, pcm4); end
        end
      end
    end
  endtask

  task automatic test_random();
    int   nout = 0;
    logic ev;
    restart4();
    for (int t = 0; t < 160; t++) begin
      tick4(1'($urandom));
      ev = ((t + 1) % 4) == 0;
      n_tests++;
      if (vld4 !== ev) begin n_fail++; $display("FAIL rand valid t=%0d got %b exp %b", t, vld4, ev); end
      if (ev) begin
        nout++;
        n_tests++;
        if (longint'(pcm4) !== model_out(2, nout))
          begin n_fail++; $display("FAIL rand word %0d got %0d exp %0d", nout, pcm4, model_out(2, nout)); end
      end
    end
  endtask

  task automatic test_mid_reset();
    longint tbl[3] = '{4, 44, 64};
    int     nout = 0;
    logic   ev;
    restart4();
    for (int t = 0; t < 10; t++) tick4(1'b1);
    rst4 = 1'b0;
    tick4(1'b1);
    n_tests += 2;
    if (pcm4 !== 8'sd0) begin n_fail++; $display("FAIL midrst pcm got %0d exp 0", pcm4); end
    if (vld4 !== 1'b0)  begin n_fail++; $display("FAIL midrst valid got %b exp 0", vld4); end
    rst4 = 1'b1;
    stim.delete();
    for (int t = 0; t < 12; t++) begin
      tick4(1'b1);
      ev = ((t + 1) % 4) == 0;
      n_tests++;
      if (vld4 !== ev) begin n_fail++; $display("FAIL midrst valid t=%0d got %b exp %b", t, vld4, ev); end
      if (ev) begin
        nout++;
        n_tests++;
        if (longint'(pcm4) !== tbl[nout - 1])
          begin n_fail++; $display("FAIL midrst word %0d got %0d exp %0d", nout, pcm4, tbl[nout - 1]); end
      end
    end
  endtask

  task automatic test_wrap_r64();
    int   nout = 0;
    logic ev;
    restart64();
    for (int t = 0; t < 5000; t++) begin
      tick64(1'b1);
      ev = ((t + 1) % 64) == 0;
      n_tests++;
      if (vld64 !== ev) begin n_fail++; $display("FAIL wrap valid t=%0d got %b exp %b", t, vld64, ev); end
      if (ev) begin
        nout++;
        n_tests++;
        if (longint'(pcm64) !== model_out(6, nout))
          begin n_fail++; $display("FAIL wrap model word %0d got %0d exp %0d", nout, pcm64, model_out(6, nout)); end
        if (nout >= 3) begin
          n_tests++;
          if (longint'(pcm64) !== 262144)
            begin n_fail++; $display("FAIL wrap word %0d got %0d exp 262144", nout, pcm64); end
        end
      end
    end
  endtask

  task automatic test_modulator();
    longint u = 8192, fs = 32768, v1 = 0, v2 = 0, y = -fs;
    real    sum = 0.0, avg;
    int     nout = 0;
    bit     b;
    restart64();
    for (int t = 0; t < 66 * 64; t++) begin
      b = (y > 0);
      tick64(b);
      v1 += u - y;
      v2 += v1 - y;
      y = (v2 >= 0) ? fs : -fs;
      if (((t + 1) % 64) == 0) begin
        nout++;
        n_tests++;
        if (longint'(pcm64) !== model_out(6, nout))
          begin n_fail++; $display("FAIL sd2 word %0d got %0d exp %0d", nout, pcm64, model_out(6, nout)); end
        if (nout >= 3) sum += real'(pcm64) / 262144.0;
      end
    end
    avg = sum / 64.0;
    n_tests++;
    if (avg < 0.24 || avg > 0.26)
      begin n_fail++; $display("FAIL sd2 average got %f exp 0.25+-0.01", avg); end
  endtask

  initial begin
    rst4 = 1'b0; bs4 = 1'b0;
    rst64 = 1'b0; bs64 = 1'b0;
    test_reset();
    test_constant(1'b1);
    test_constant(1'b0);
    test_alternating();
    test_random();
    test_mid_reset();
    test_wrap_r64();
    test_modulator();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
